// File: rtl/masking_pkg.sv
// Shared constants and types for the masked AND driver.
// Two-share masking with a 16-bit Fibonacci LFSR as randomness source.
package masking_pkg;

    localparam int D         = 2;
    localparam int RAND_SIZE = D * (D - 1) / 2;
    localparam int TIMEOUT   = 15;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 counted from the output end of a right shift
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/masked_and_driver_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and zero-state guard.
// Load has priority over step; a zero seed maps to the default seed.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    import masking_pkg::*;

    logic [15:0] nxt;
    logic        fb;

    // Next-state selection: load, step or hold, never zero
    always_comb begin
        fb  = ^(value & LFSR_TAPS);
        nxt = value;
        if (load) begin
            nxt = seed;
        end else if (step) begin
            nxt = {fb, value[15:1]};
        end
        if (nxt == 16'h0000) begin
            nxt = LFSR_SEED;
        end
    end

    // State register, reset to the default seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: rtl/masked_and_driver.sv
// Driver for an external 2-share masked AND gadget.
// Masks operands, runs the gadget with a timeout, recombines the result.
module masked_and_driver #(
    parameter int D       = masking_pkg::D,
    parameter int TIMEOUT = masking_pkg::TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     a_in,
    input  logic                     b_in,
    input  logic                     seed_load,
    input  logic [15:0]              seed_in,
    output logic                     busy,
    output logic                     result,
    output logic                     result_valid,
    output logic                     err,
    output logic [D-1:0]             ina,
    output logic [D-1:0]             inb,
    output logic [D*(D-1)/2-1:0]     rin,
    output logic                     and_enable,
    input  logic                     and_done,
    input  logic [D-1:0]             and_out
);
    import masking_pkg::*;

    // Only the two-share gadget is supported by the share wiring below
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        start_q;
    logic        accept;
    logic        seed_ok;
    logic        step;
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    // A held start counts as one request; only a fresh rise is accepted
    assign accept  = (state == IDLE) && start && !start_q;
    assign seed_ok = (state == IDLE) && seed_load;
    assign step    = accept && !seed_load;

    assign lfsr_unused = ^lfsr_q[15:3];

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (step),
        .load  (seed_ok),
        .seed  (seed_in),
        .value (lfsr_q)
    );

    // Outputs decoded from the state so reset clears them at once
    assign busy         = (state != IDLE);
    assign and_enable   = (state == RUN);
    assign result_valid = (state == DONE);
    assign err          = (state == ERR);

    // Next-state logic; done beats a same-cycle timeout
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (and_done) begin
                    state_nxt = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and start edge tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
        end
    end

    // Wait counter: cleared on accept, counts RUN cycles without done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= 4'd0;
        end else if (state == RUN && !and_done) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Share registers, loaded from the pre-step LFSR state on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ina <= '0;
            inb <= '0;
            rin <= '0;
        end else if (accept) begin
            ina <= {a_in ^ lfsr_q[0], lfsr_q[0]};
            inb <= {b_in ^ lfsr_q[1], lfsr_q[1]};
            rin <= lfsr_q[2];
        end
    end

    // Recombined result, captured only on done while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 1'b0;
        end else if (state == RUN && and_done) begin
            result <= and_out[0] ^ and_out[1];
        end
    end

endmodule

// File: tb/tb_masked_and_driver.sv
// Self-checking bench for masked_and_driver with a 2-share DOM AND model.
// Reference LFSR and expected results are computed from the rules directly.
module tb_masked_and_driver;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        a_in;
    logic        b_in;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        busy;
    logic        result;
    logic        result_valid;
    logic        err;
    logic [1:0]  ina;
    logic [1:0]  inb;
    logic [0:0]  rin;
    logic        and_enable;
    logic        and_done;
    logic [1:0]  and_out;

    logic [1:0]  g_cnt;
    logic        gadget_hang;

    int          n_pass;
    int          n_checks;
    logic [15:0] m_lfsr;
    logic        m_result;

    masked_and_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .seed_load    (seed_load),
        .seed_in      (seed_in),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .ina          (ina),
        .inb          (inb),
        .rin          (rin),
        .and_enable   (and_enable),
        .and_done     (and_done),
        .and_out      (and_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gadget model: done three cycles into an enable window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_cnt <= 2'd0;
        end else if (!and_enable) begin
            g_cnt <= 2'd0;
        end else if (g_cnt != 2'd3) begin
            g_cnt <= g_cnt + 2'd1;
        end
    end

    assign and_done   = (g_cnt == 2'd3) && !gadget_hang;
    assign and_out[0] = (ina[0] & inb[0]) ^ ((ina[0] & inb[1]) ^ rin[0]);
    assign and_out[1] = (ina[1] & inb[1]) ^ ((ina[1] & inb[0]) ^ rin[0]);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return (s >> 1) | (16'(fb) << 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic a, input logic b,
                          input bit with_seed, input logic [15:0] seed);
        logic [15:0] r;
        int          k;
        r         = m_lfsr;
        start     = 1'b1;
        a_in      = a;
        b_in      = b;
        seed_load = with_seed;
        seed_in   = seed;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
        if (with_seed) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
        else           m_lfsr = lfsr_step(m_lfsr);
        chk("busy_accept", 32'(busy), 32'd1);
        chk("ina", 32'(ina), 32'({a ^ r[0], r[0]}));
        chk("inb", 32'(inb), 32'({b ^ r[1], r[1]}));
        chk("rin", 32'(rin), 32'(r[2]));
        chk("en_run", 32'(and_enable), 32'd1);
        chk("lfsr_after_accept", 32'(dut.lfsr_q), 32'(m_lfsr));
        k = 0;
        while (!result_valid && k < 40) begin
            tick();
            k++;
        end
        m_result = a & b;
        chk("latency", 32'(k), 32'd4);
        chk("result", 32'(result), 32'(m_result));
        chk("ina_stable", 32'(ina), 32'({a ^ r[0], r[0]}));
        chk("en_done", 32'(and_enable), 32'd0);
        tick();
        chk("rv_pulse", 32'(result_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'(m_result));
    endtask

    initial begin
        int k;
        int cnt;
        int cnt2;
        logic a;
        logic b;
        n_pass      = 0;
        n_checks    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a_in        = 1'b0;
        b_in        = 1'b0;
        seed_load   = 1'b0;
        seed_in     = 16'h0;
        gadget_hang = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ina", 32'(ina), 32'd0);
        chk("rst_inb", 32'(inb), 32'd0);
        chk("rst_rin", 32'(rin), 32'd0);
        chk("rst_en", 32'(and_enable), 32'd0);
        chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        rst_n    = 1'b1;
        m_lfsr   = 16'hACE1;
        m_result = 1'b0;
        tick();

        // All four operand combinations
        for (int i = 0; i < 4; i++) begin
            run_op(i[1], i[0], 1'b0, 16'h0);
        end

        // Seed 0x0001 then two ops
        seed_load = 1'b1;
        seed_in   = 16'h0001;
        tick();
        seed_load = 1'b0;
        m_lfsr    = 16'h0001;
        chk("seed_0001", 32'(dut.lfsr_q), 32'h0001);
        run_op(1'($urandom), 1'($urandom), 1'b0, 16'h0);
        run_op(1'($urandom), 1'($urandom), 1'b0, 16'h0);

        // Gadget that never finishes
        gadget_hang = 1'b1;
        start = 1'b1;
        a_in  = ~m_result;
        b_in  = ~m_result;
        tick();
        start  = 1'b0;
        m_lfsr = lfsr_step(m_lfsr);
        k   = 0;
        cnt = 0;
        while (!err && k < 40) begin
            if (and_enable) cnt++;
            tick();
            k++;
        end
        chk("err_latency", 32'(k), 32'd15);
        chk("err_en_cycles", 32'(cnt), 32'd15);
        chk("err_en_low", 32'(and_enable), 32'd0);
        chk("err_no_rv", 32'(result_valid), 32'd0);
        chk("err_result", 32'(result), 32'(m_result));
        tick();
        chk("err_pulse", 32'(err), 32'd0);
        chk("err_idle", 32'(busy), 32'd0);
        chk("err_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        gadget_hang = 1'b0;

        // Start held for ten cycles, seed_load while busy
        a = 1'($urandom);
        b = 1'($urandom);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cnt   = 0;
        for (int i = 0; i < 10; i++) begin
            seed_load = (i == 2);
            seed_in   = 16'h5555;
            tick();
            if (result_valid) cnt++;
        end
        start     = 1'b0;
        seed_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (result_valid) cnt++;
        end
        m_lfsr   = lfsr_step(m_lfsr);
        m_result = a & b;
        chk("hold_rv_count", 32'(cnt), 32'd1);
        chk("hold_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        chk("hold_result", 32'(result), 32'(m_result));
        chk("hold_idle", 32'(busy), 32'd0);

        // Reset while running
        start = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_en", 32'(and_enable), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_ina", 32'(ina), 32'd0);
        chk("mid_inb", 32'(inb), 32'd0);
        chk("mid_rin", 32'(rin), 32'd0);
        chk("mid_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        tick();
        tick();
        rst_n    = 1'b1;
        m_lfsr   = 16'hACE1;
        m_result = 1'b0;
        cnt  = 0;
        cnt2 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (result_valid) cnt++;
            if (err) cnt2++;
        end
        chk("mid_no_rv", 32'(cnt), 32'd0);
        chk("mid_no_err", 32'(cnt2), 32'd0);
        run_op(1'($urandom), 1'($urandom), 1'b0, 16'h0);

        // Zero seed, then start together with seed_load
        seed_load = 1'b1;
        seed_in   = 16'h0000;
        tick();
        seed_load = 1'b0;
        m_lfsr    = 16'hACE1;
        chk("seed_zero", 32'(dut.lfsr_q), 32'hACE1);
        run_op(1'b1, 1'b1, 1'b1, 16'h1234);
        run_op(1'($urandom), 1'($urandom), 1'b0, 16'h0);

        // Random operations with occasional reseeds
        for (int i = 0; i < 8; i++) begin
            run_op(1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/masked_and_driver.md
MASKED_AND_DRIVER -- requirements
Module: masked_and_driver

Interface
REQ-001 Parameter D, default 2, number of shares per operand; this revision SHALL support D=2 only.
REQ-002 Parameter TIMEOUT, default 15, maximum wait cycles for the gadget's done.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request pulse; accepted only when busy=0.
REQ-006 a_in, b_in  input  1 each  unmasked operands, sampled on the accept edge.
REQ-007 seed_load  input  1  loads seed_in into the LFSR; ignored when busy=1.
REQ-008 seed_in  input  16  LFSR seed.
REQ-009 busy  output  1  high from the cycle after accept until return to IDLE.
REQ-010 result  output  1  recombined AND result, valid while result_valid=1.
REQ-011 result_valid  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle timeout pulse.
REQ-013 ina, inb  output  D  masked operand shares to the gadget.
REQ-014 rin  output  D*(D-1)/2  fresh refresh randomness to the gadget.
REQ-015 and_enable  output  1  gadget enable.
REQ-016 and_done  input  1  gadget completion.
REQ-017 and_out  input  D  gadget output shares.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, RUN, DONE, ERR.
REQ-019 In IDLE with start=1, the block SHALL accept the request: register ina={a_in^r[0], r[0]}, inb={b_in^r[1], r[1]}, rin=r[2] (r = current LFSR state), advance the LFSR once, and enter RUN.
REQ-020 In RUN, and_enable SHALL be 1, and ina/inb/rin SHALL remain stable.
REQ-021 In RUN, and_done=1 SHALL capture result=and_out[0]^and_out[1], drop and_enable, and enter DONE.
REQ-022 DONE SHALL assert result_valid for exactly one cycle, then return to IDLE; result SHALL hold until the next accept.
REQ-023 A 4-bit wait counter SHALL clear on accept and increment in each RUN cycle without done; reaching TIMEOUT SHALL drop and_enable and enter ERR.
REQ-024 ERR SHALL pulse err for one cycle, leave result unchanged, and return to IDLE.
REQ-025 If and_done=1 in the same cycle the counter reaches TIMEOUT, done SHALL win.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 and_done outside RUN SHALL be ignored.
REQ-028 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11 and SHALL advance only on accept.
REQ-029 seed_load with seed_in=0 SHALL load 16'hACE1; the LFSR SHALL never hold zero.
REQ-030 When start and seed_load arrive together in IDLE, the seed SHALL load, the request SHALL be accepted using the pre-load state, and no LFSR advance SHALL occur that cycle.
REQ-031 Minimum accept-to-result_valid latency SHALL be 1 cycle plus the gadget's done latency plus 1 cycle.

Reset
REQ-032 While rst_n=0, the state SHALL be IDLE, the LFSR SHALL be 16'hACE1, the counter SHALL be 0, and all outputs (busy, result, result_valid, err, ina, inb, rin, and_enable) SHALL be 0.
REQ-033 Reset in RUN SHALL drop and_enable immediately and asynchronously, and no result_valid or err SHALL follow.

Structure
REQ-034 Package masking_pkg SHALL hold D, RAND_SIZE, LFSR_SEED=16'hACE1, the LFSR taps, TIMEOUT and the state enum.
REQ-035 Sub-module lfsr16 SHALL hold the LFSR (step, load, zero-guard).
REQ-036 The gadget SHALL NOT be instantiated inside this block.

Verification
REQ-037 Connect the 2-share AND gadget; apply all four (a,b) combinations -> result = a&b, result_valid rising 4 cycles after accept, busy low afterwards.
REQ-038 seed_load with seed_in=16'h0001, then two ops -> ina[1], inb[1], rin match the reference-model LFSR bits, and the LFSR advances once per op.
REQ-039 Gadget model that never asserts done -> err pulses after 15 RUN cycles, and_enable drops, result unchanged.
REQ-040 start held high for 10 cycles -> exactly one accept, extra starts ignored, single result_valid.
REQ-041 rst_n low mid-RUN -> all outputs 0, LFSR=16'hACE1; a new op after release completes correctly.
REQ-042 seed_load with seed_in=0 -> LFSR=16'hACE1; simultaneous start and seed_load -> shares use the pre-load LFSR state.
